// File: rtl/paddle_ctrl.sv
// Per-player paddle: resynchronises and debounces the keypad, runs an IDLE/UP/DOWN FSM and moves the paddle once per frame.
// Key-to-state latency is 2 sync + DEB_CYCLES + 1 clocks; position updates on the edge after frame_tick. No backpressure: every tick is consumed.
module paddle_ctrl #(
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned PADDLE_H    = 64,
  parameter int unsigned Y_INIT      = 208,
  parameter int unsigned STEP        = 4,
  parameter int unsigned FAST_STEP   = 8,
  parameter int unsigned HOLD_FRAMES = 30,
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter logic [3:0]  KEY_UP      = 4'h2,
  parameter logic [3:0]  KEY_DOWN    = 4'h8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [3:0] keycode,
  input  logic       keypressed,
  output logic [9:0] paddle_y,
  output logic       moving_up,
  output logic       moving_dn,
  output logic       fast
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [DW-1:0]      DEB_MAX  = DW'(DEB_CYCLES);
  localparam logic [DW-1:0]      DEB_FIRE = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0]      HOLD_MAX = HW'(HOLD_FRAMES);
  localparam logic signed [10:0] Y_MAX    = 11'(SCREEN_H - PADDLE_H);
  localparam logic signed [10:0] STEP_N   = 11'(STEP);
  localparam logic signed [10:0] STEP_F   = 11'(FAST_STEP);
  localparam logic [9:0]         Y_RST    = 10'(Y_INIT);

  typedef struct packed {
    logic       pressed;
    logic [3:0] code;
  } key_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  key_t key_meta_d, key_meta_q;
  key_t raw_s_d,    raw_s_q;
  key_t raw_prev_d, raw_prev_q;
  key_t filt_d,     filt_q;

  logic [DW-1:0] deb_cnt_d, deb_cnt_q;
  logic [HW-1:0] hold_cnt_d, hold_cnt_q;
  logic          fast_d, fast_q;
  logic [9:0]    paddle_y_d, paddle_y_q;
  state_t        state_d, state_q;

  logic          raw_stable;
  logic          up_req;
  logic          dn_req;
  logic          moving;
  logic signed [10:0] y_ext;
  logic signed [10:0] step_s;
  logic signed [10:0] y_up;
  logic signed [10:0] y_dn;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta_q <= '0;
      raw_s_q    <= '0;
      raw_prev_q <= '0;
      filt_q     <= '0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      fast_q     <= 1'b0;
      paddle_y_q <= Y_RST;
      state_q    <= ST_IDLE;
    end else begin
      key_meta_q <= key_meta_d;
      raw_s_q    <= raw_s_d;
      raw_prev_q <= raw_prev_d;
      filt_q     <= filt_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      fast_q     <= fast_d;
      paddle_y_q <= paddle_y_d;
      state_q    <= state_d;
    end
  end

  // Two-flop resync, then the filter only follows raw_s once it has held still long enough.
  always_comb begin
    key_meta_d = '{pressed: keypressed, code: keycode};
    raw_s_d    = key_meta_q;
    raw_prev_d = raw_s_q;
    raw_stable = (raw_s_q == raw_prev_q);
    deb_cnt_d  = '0;
    filt_d     = filt_q;
    if (raw_stable) begin
      if (deb_cnt_q != DEB_MAX) begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end else begin
        deb_cnt_d = deb_cnt_q;
      end
      if (deb_cnt_d == DEB_FIRE) begin
        filt_d = raw_s_q;
      end
    end
  end

  always_comb begin
    up_req = filt_q.pressed && (filt_q.code == KEY_UP);
    dn_req = filt_q.pressed && (filt_q.code == KEY_DOWN);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (up_req) begin
          state_d = ST_UP;
        end else if (dn_req) begin
          state_d = ST_DOWN;
        end
      end
      ST_UP: begin
        if (!up_req) begin
          state_d = dn_req ? ST_DOWN : ST_IDLE;
        end
      end
      ST_DOWN: begin
        if (!dn_req) begin
          state_d = up_req ? ST_UP : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A state change always restarts acceleration, even if a tick lands in the same cycle.
  always_comb begin
    moving     = (state_q != ST_IDLE);
    hold_cnt_d = hold_cnt_q;
    fast_d     = fast_q;
    if (state_d != state_q) begin
      hold_cnt_d = '0;
      fast_d     = 1'b0;
    end else if (frame_tick && moving) begin
      if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
      if (hold_cnt_d == HOLD_MAX) begin
        fast_d = 1'b1;
      end
    end
  end

  // Movement uses the registered state and step, so a transition or a newly set fast flag takes effect next frame.
  always_comb begin
    y_ext      = {1'b0, paddle_y_q};
    step_s     = fast_q ? STEP_F : STEP_N;
    y_up       = y_ext - step_s;
    y_dn       = y_ext + step_s;
    paddle_y_d = paddle_y_q;
    if (frame_tick) begin
      case (state_q)
        ST_UP:   paddle_y_d = y_up[10] ? 10'd0 : y_up[9:0];
        ST_DOWN: paddle_y_d = (y_dn > Y_MAX) ? Y_MAX[9:0] : y_dn[9:0];
        default: paddle_y_d = paddle_y_q;
      endcase
    end
  end

  always_comb begin
    paddle_y  = paddle_y_q;
    moving_up = (state_q == ST_UP);
    moving_dn = (state_q == ST_DOWN);
    fast      = fast_q;
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with short debounce and hold thresholds; expected values are hand-computed.
module tb_paddle_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic [3:0] keycode;
  logic       keypressed;
  logic [9:0] paddle_y;
  logic       moving_up;
  logic       moving_dn;
  logic       fast;

  int n_cmp;
  int n_bad;

  paddle_ctrl #(
    .DEB_CYCLES  (4),
    .HOLD_FRAMES (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .keypressed (keypressed),
    .paddle_y   (paddle_y),
    .moving_up  (moving_up),
    .moving_dn  (moving_dn),
    .fast       (fast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame: tick sampled on the next rising edge, then idle to a 20-clock frame.
  task automatic do_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (18) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check_val("rst_y", 32'(paddle_y), 32'd208);
    check_val("rst_up", 32'(moving_up), 32'd0);
    check_val("rst_dn", 32'(moving_dn), 32'd0);
    check_val("rst_fast", 32'(fast), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic seen_move;
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    frame_tick = 1'b0;
    keycode    = 4'h0;
    keypressed = 1'b0;
    repeat (2) @(negedge clk);
    check_val("init_y", 32'(paddle_y), 32'd208);
    check_val("init_up", 32'(moving_up), 32'd0);
    check_val("init_dn", 32'(moving_dn), 32'd0);
    check_val("init_fast", 32'(fast), 32'd0);
    rst = 1'b0;

    // No key for 100 clocks: paddle stays centred.
    repeat (5) do_tick();
    check_val("idle_y", 32'(paddle_y), 32'd208);
    check_val("idle_up", 32'(moving_up), 32'd0);

    // Press UP: state follows 2 sync + 4 debounce + 1 clocks later.
    keycode    = 4'h2;
    keypressed = 1'b1;
    repeat (6) @(negedge clk);
    check_val("lat_up_early", 32'(moving_up), 32'd0);
    @(negedge clk);
    check_val("lat_up_on", 32'(moving_up), 32'd1);
    do_tick();
    check_val("up_t1", 32'(paddle_y), 32'd204);
    do_tick();
    check_val("up_t2", 32'(paddle_y), 32'd200);
    check_val("up_t2_fast", 32'(fast), 32'd0);
    do_tick();
    check_val("up_t3", 32'(paddle_y), 32'd196);
    check_val("up_t3_fast", 32'(fast), 32'd1);
    do_tick();
    check_val("up_t4", 32'(paddle_y), 32'd188);

    // Release: back to IDLE, fast dropped.
    keypressed = 1'b0;
    keycode    = 4'h0;
    repeat (10) @(negedge clk);
    check_val("rel_up", 32'(moving_up), 32'd0);
    check_val("rel_fast", 32'(fast), 32'd0);

    // DOWN from centre: 212,216,220 then +8 each frame reaches 412 on frame 27.
    do_reset();
    keycode    = 4'h8;
    keypressed = 1'b1;
    repeat (7) @(negedge clk);
    check_val("dn_on", 32'(moving_dn), 32'd1);
    repeat (27) do_tick();
    check_val("dn_412", 32'(paddle_y), 32'd412);
    check_val("dn_fast", 32'(fast), 32'd1);
    do_tick();
    check_val("dn_sat1", 32'(paddle_y), 32'd416);
    do_tick();
    check_val("dn_sat2", 32'(paddle_y), 32'd416);
    do_tick();
    check_val("dn_sat3", 32'(paddle_y), 32'd416);

    // Switch straight to UP: 412,408,404 then -8 each frame reaches 4 on frame 53.
    keycode = 4'h2;
    repeat (7) @(negedge clk);
    check_val("sw_up", 32'(moving_up), 32'd1);
    check_val("sw_dn", 32'(moving_dn), 32'd0);
    check_val("sw_fast", 32'(fast), 32'd0);
    repeat (53) do_tick();
    check_val("top_4", 32'(paddle_y), 32'd4);
    check_val("top_fast", 32'(fast), 32'd1);
    do_tick();
    check_val("top_sat1", 32'(paddle_y), 32'd0);
    do_tick();
    check_val("top_sat2", 32'(paddle_y), 32'd0);

    // Release, then a 3-clock DOWN glitch must never reach the FSM.
    keypressed = 1'b0;
    keycode    = 4'h0;
    repeat (10) @(negedge clk);
    check_val("gl_idle", 32'(moving_up), 32'd0);
    keycode    = 4'h8;
    keypressed = 1'b1;
    repeat (3) @(negedge clk);
    keycode    = 4'h0;
    keypressed = 1'b0;
    seen_move  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      frame_tick = (i == 12);
      @(negedge clk);
      if (moving_dn || moving_up) seen_move = 1'b1;
    end
    frame_tick = 1'b0;
    check_val("gl_move", 32'(seen_move), 32'd0);
    check_val("gl_y", 32'(paddle_y), 32'd0);

    // UP to 200, then switch to DOWN with a tick landing in the transition cycle.
    do_reset();
    keycode    = 4'h2;
    keypressed = 1'b1;
    repeat (10) @(negedge clk);
    do_tick();
    do_tick();
    check_val("tr_pre", 32'(paddle_y), 32'd200);
    keycode = 4'h8;
    repeat (6) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check_val("tr_y", 32'(paddle_y), 32'd196);
    check_val("tr_dn", 32'(moving_dn), 32'd1);
    check_val("tr_up", 32'(moving_up), 32'd0);
    check_val("tr_fast", 32'(fast), 32'd0);
    repeat (18) @(negedge clk);
    do_tick();
    check_val("tr_t1", 32'(paddle_y), 32'd200);
    check_val("tr_t1_fast", 32'(fast), 32'd0);
    do_tick();
    check_val("tr_t2", 32'(paddle_y), 32'd204);
    check_val("tr_t2_fast", 32'(fast), 32'd0);
    do_tick();
    check_val("tr_t3", 32'(paddle_y), 32'd208);
    check_val("tr_t3_fast", 32'(fast), 32'd1);
    do_tick();
    check_val("tr_t4", 32'(paddle_y), 32'd216);

    // Reset mid-hold with DOWN still held: values return, then the key is re-debounced.
    do_reset();
    repeat (6) @(negedge clk);
    check_val("rd_early", 32'(moving_dn), 32'd0);
    @(negedge clk);
    check_val("rd_on", 32'(moving_dn), 32'd1);
    check_val("rd_y", 32'(paddle_y), 32'd208);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
